tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer: the receive-side counterpart of the team's `mux` primitive. It takes one time-multiplexed sample stream, carrying channel 0 first and marked by a start-of-frame flag. Each sample is steered into one of N per-channel holding registers by a frame-locked channel counter. It sits after any serial/TDM link that carries several narrow channels on one data path, and produces one held value plus a one-cycle strobe per channel.

## Interface
- `W`, default 8: sample width in bits.
- `N`, default 4: channels per frame; minimum 2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample present this cycle; there is no backpressure, so a valid sample is always consumed.
- `in_sof`  in  1  start of frame; qualified by `in_valid`; marks channel 0.
- `in_data`  in  W  sample value.
- `out_data`  out  N*W  holding registers; channel c occupies bits [c*W +: W].
- `out_valid`  out  N  one-hot, one-cycle strobe: bit c is high for the cycle after channel c's register updates.
- `frame_done`  out  1  one-cycle pulse when channel N-1 is written.
- `locked`  out  1  high in LOCK state.
- `sync_err`  out  1  one-cycle pulse when a start of frame arrives mid-frame.

## Operation
- The state machine has two states, HUNT and LOCK. The channel counter `ch` is $clog2(N) bits wide.
- In HUNT:
  - A valid sample without `in_sof` is dropped: no write and no strobe.
  - A valid sample with `in_sof` writes channel 0, sets `ch` to 1 and moves to LOCK.
- In LOCK, for a valid sample without `in_sof`:
  - It writes channel `ch`, then `ch` increments.
  - When `ch` == N-1, `frame_done` pulses and `ch` wraps to 0.
- In LOCK, for a valid sample with `in_sof`:
  - If `ch` == 0, it is a normal channel-0 write.
  - If `ch` != 0, `sync_err` pulses, the sample is written as channel 0 and `ch` is set to 1. This is a resync; the state stays LOCK and the partial frame is not flagged `frame_done`.
  - The `ch` == 0 case also covers the wrap: `in_sof` arriving right after the `frame_done` sample is legal.
- `in_valid` = 0 means no state change. Gaps of any length inside a frame are legal.
- Strobe rules:
  - At most one `out_valid` bit is set per cycle.
  - Registers of channels not written hold their values.
  - `in_sof` without `in_valid` is ignored.
- LOCK is left only via reset.

## Timing
- Latency is 1 cycle: a sample accepted at edge k is visible on `out_data` with its strobe after edge k, and the strobe clears after edge k+1 unless another write occurs.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back valid samples are accepted every cycle, so full throughput is 1 sample/clk.
- Reset values:
  - `out_data` = 0, `out_valid` = 0, `frame_done` = 0, `sync_err` = 0, `locked` = 0.
  - State = HUNT, `ch` = 0.
- Reset asserted mid-frame clears everything immediately (asynchronous). The first sample after deassertion is accepted only if it carries `in_sof`.
- `frame_done` and `out_valid[N-1]` assert in the same cycle.
- `sync_err` and `out_valid[0]` assert in the same cycle.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- When defined:
  - An extra input `in_par` (1 bit, even parity over `in_data`) and an extra output `par_err` (1-bit registered pulse, reset 0) are present.
  - On a parity mismatch (XOR-reduction of `in_data` != `in_par`) for an accepted sample: the register is not updated and its `out_valid` bit does not pulse. `par_err` pulses, `ch` still advances and state transitions still happen. A failing sample that would be channel N-1 still produces `frame_done`.
  - A parity-bad sample received in HUNT is dropped and produces no `par_err` pulse.
- When undefined: neither port exists and all samples are treated as good.

## Structure
- Package `tdm_demux_pkg` holds:
  - the state enum `tdm_state_t` {HUNT, LOCK};
  - the default constants `TDM_W` = 8 and `TDM_N` = 4.
- Sub-module `tdm_ch_counter`: a mod-N counter with `clr_to_one`, `inc` and a `wrap` output. The top level holds the state machine and the holding registers.

## Test plan
- Reset, then N=4, W=8: stream 0x11 (`in_sof`), 0x22, 0x33, 0x44 on consecutive cycles -> `out_valid` = 0001, 0010, 0100, 1000 on cycles 1-4; `out_data` = 0x44332211; `frame_done` pulses together with 1000; `locked` = 1 after the first sample.
- Three samples without `in_sof` after reset -> no strobes, `locked` = 0, `out_data` = 0. The next sample, 0xAA with `in_sof` -> `out_valid` = 0001, channel 0 = 0xAA.
- In LOCK with `ch` = 2, send 0x5A with `in_sof` -> `sync_err` = 1 and `out_valid` = 0001 in the same cycle, channel 0 = 0x5A; the next sample lands in channel 1; no `frame_done`.
- Insert 3 idle cycles between channel 1 and channel 2 samples -> no strobes during the gap; channel 2 is written correctly and `frame_done` is still on channel 3.
- Assert `rst_n` low for 1 cycle mid-frame after channel 1 -> all outputs 0 and `locked` = 0 immediately; a following non-`in_sof` sample is dropped.
- With `TDM_DEMUX_PARITY_EN`, channel 1 sample 0x03 with `in_par` = 1 -> `par_err` = 1, no `out_valid[1]`, channel 1 unchanged; the next sample is written to channel 2.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared state type and default sizes for the TDM demultiplexer
package tdm_demux_pkg;

  localparam int TDM_W = 8;
  localparam int TDM_N = 4;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_ch_counter.sv
// rtl/tdm_ch_counter.sv - frame-locked mod-N channel counter with load-to-one and wrap flag
module tdm_ch_counter
  import tdm_demux_pkg::*;
#(
  parameter int N = TDM_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_to_one,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] ch,
  output logic                 wrap
);

  localparam int CW = $clog2(N);

  assign wrap = (ch == CW'(N - 1));

  // Channel 0 is consumed by the sample that loads the counter, so a load goes to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch <= '0;
    end else if (clr_to_one) begin
      ch <= CW'(1);
    end else if (inc) begin
      ch <= wrap ? '0 : ch + CW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM demultiplexer top; optional parity check under TDM_DEMUX_PARITY_EN
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int W = TDM_W,
  parameter int N = TDM_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           in_sof,
  input  logic [W-1:0]   in_data,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic           in_par,
  output logic           par_err,
`endif
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_valid,
  output logic           frame_done,
  output logic           locked,
  output logic           sync_err
);

  localparam int CW = $clog2(N);

  tdm_state_t    state, state_nxt;
  logic [CW-1:0] ch;
  logic          wrap;
  logic          cnt_clr, cnt_inc;
  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic          fd_nxt, se_nxt;
  logic          good;

`ifdef TDM_DEMUX_PARITY_EN
  assign good = ((^in_data) == in_par);
`else
  assign good = 1'b1;
`endif

  assign locked = (state == LOCK);

  tdm_ch_counter #(.N(N)) u_ch_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_to_one (cnt_clr),
    .inc        (cnt_inc),
    .ch         (ch),
    .wrap       (wrap)
  );

  // State register; LOCK is only ever left through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Decide where an accepted sample goes and how the counter and flags move.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wr_en     = 1'b0;
    wr_ch     = '0;
    fd_nxt    = 1'b0;
    se_nxt    = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          // A corrupted start of frame cannot be trusted for alignment, so it is dropped.
          if (in_sof && good) begin
            wr_en     = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (in_sof && (ch != '0)) begin
            se_nxt  = 1'b1;
            cnt_clr = 1'b1;
            wr_en   = good;
          end else begin
            wr_ch   = ch;
            wr_en   = good;
            cnt_inc = 1'b1;
            fd_nxt  = wrap;
          end
        end
        default: ;
      endcase
    end
  end

  // Holding registers and one-cycle strobes, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      out_valid  <= '0;
      frame_done <= fd_nxt;
      sync_err   <= se_nxt;
      for (int c = 0; c < N; c++) begin
        if (wr_en && (wr_ch == CW'(c))) begin
          out_valid[c]      <= 1'b1;
          out_data[c*W +: W] <= in_data;
        end
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity errors are only reported once aligned; HUNT drops bad samples silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= in_valid && (state == LOCK) && !good;
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - self-checking bench for tdm_demux against a frame-level reference model
module tb_tdm_demux;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_sof = 1'b0;
  logic [W-1:0]   in_data = '0;
`ifdef TDM_DEMUX_PARITY_EN
  logic           in_par = 1'b0;
  logic           par_err;
`endif
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic           frame_done, locked, sync_err;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: held values per channel, lock flag, next expected channel
  logic [W-1:0]   m_held [N];
  bit             m_lock;
  int             m_ch;
  logic [N*W-1:0] e_data;
  logic [N-1:0]   e_valid;
  logic           e_fd, e_se, e_pe;

  always #5 clk = ~clk;

  tdm_demux #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
`ifdef TDM_DEMUX_PARITY_EN
    .in_par     (in_par),
    .par_err    (par_err),
`endif
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_held[c] = '0;
    m_lock = 0; m_ch = 0;
    e_data = '0; e_valid = '0; e_fd = 0; e_se = 0; e_pe = 0;
  endtask

  task automatic do_reset();
    in_valid = 0; in_sof = 0; in_data = '0;
`ifdef TDM_DEMUX_PARITY_EN
    in_par = 0;
`endif
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  // Apply one cycle of input, then advance the model by the frame rules.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d, input logic bad);
    bit good;
    int tgt;
    in_valid = v; in_sof = s; in_data = d;
`ifdef TDM_DEMUX_PARITY_EN
    in_par = (^d) ^ bad;
    good = !bad;
`else
    good = 1;
`endif
    @(posedge clk);
    #1;
    e_valid = '0; e_fd = 0; e_se = 0; e_pe = 0;
    if (v) begin
      if (!m_lock) begin
        if (s && good) begin
          m_held[0] = d; e_valid = 1; m_lock = 1; m_ch = 1;
        end
      end else begin
        e_pe = !good;
        if (s && m_ch != 0) begin
          e_se = 1; tgt = 0; m_ch = 1;
        end else begin
          tgt = m_ch;
          if (m_ch == N - 1) e_fd = 1;
          m_ch = (m_ch + 1) % N;
        end
        if (good) begin
          m_held[tgt] = d; e_valid = N'(1) << tgt;
        end
      end
    end
    for (int c = 0; c < N; c++) e_data[c*W +: W] = m_held[c];
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_sof = 1; in_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_data, out_valid, frame_done, sync_err, locked} !== '0) begin
      n_err++;
      $display("FAIL reset_state got data=%h valid=%b fd=%b se=%b lk=%b want all zero",
               out_data, out_valid, frame_done, sync_err, locked);
    end
    do_reset();
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] d_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [N-1:0] v_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, d_tab[i], 0);
      n_cmp++;
      if (out_valid !== v_tab[i]) begin
        n_err++; $display("FAIL basic_valid[%0d] got %b want %b", i, out_valid, v_tab[i]);
      end
      n_cmp++;
      if ({frame_done, locked} !== {i == 3, 1'b1}) begin
        n_err++; $display("FAIL basic_fd_lock[%0d] got %b%b want %b1", i, frame_done, locked, i == 3);
      end
    end
    n_cmp++;
    if (out_data !== 32'h44332211) begin
      n_err++; $display("FAIL basic_data got %h want 44332211", out_data);
    end
  endtask

  task automatic test_hunt_drop();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, W'($urandom), 0);
      n_cmp++;
      if ({out_valid, locked, out_data} !== '0) begin
        n_err++; $display("FAIL hunt_drop[%0d] got valid=%b lk=%b data=%h want zero", i, out_valid, locked, out_data);
      end
    end
    drive(1, 1, 8'hAA, 0);
    n_cmp++;
    if (out_valid !== 4'b0001 || out_data[7:0] !== 8'hAA || locked !== 1'b1) begin
      n_err++; $display("FAIL hunt_lock got valid=%b ch0=%h lk=%b want 0001 aa 1", out_valid, out_data[7:0], locked);
    end
  endtask

  task automatic test_resync();
    do_reset();
    drive(1, 1, 8'h10, 0);
    drive(1, 0, 8'h20, 0);
    drive(1, 1, 8'h5A, 0);
    n_cmp++;
    if ({sync_err, out_valid, frame_done} !== {1'b1, 4'b0001, 1'b0} || out_data[7:0] !== 8'h5A) begin
      n_err++; $display("FAIL resync got se=%b valid=%b fd=%b ch0=%h want 1 0001 0 5a",
                        sync_err, out_valid, frame_done, out_data[7:0]);
    end
    drive(1, 0, 8'h77, 0);
    n_cmp++;
    if ({sync_err, out_valid, frame_done} !== {1'b0, 4'b0010, 1'b0} || out_data[15:8] !== 8'h77) begin
      n_err++; $display("FAIL resync_next got se=%b valid=%b fd=%b ch1=%h want 0 0010 0 77",
                        sync_err, out_valid, frame_done, out_data[15:8]);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    drive(1, 1, 8'hA0, 0);
    drive(1, 0, 8'hA1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, i == 1, 8'hEE, 0);
      n_cmp++;
      if (out_valid !== '0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
        n_err++; $display("FAIL gap_idle[%0d] got valid=%b fd=%b se=%b want 0", i, out_valid, frame_done, sync_err);
      end
    end
    drive(1, 0, 8'hA2, 0);
    n_cmp++;
    if (out_valid !== 4'b0100 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL gap_ch2 got valid=%b fd=%b want 0100 0", out_valid, frame_done);
    end
    drive(1, 0, 8'hA3, 0);
    n_cmp++;
    if (out_valid !== 4'b1000 || frame_done !== 1'b1 || out_data !== 32'hA3A2A1A0) begin
      n_err++; $display("FAIL gap_ch3 got valid=%b fd=%b data=%h want 1000 1 a3a2a1a0", out_valid, frame_done, out_data);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 1, 8'hC0, 0);
    drive(1, 0, 8'hC1, 0);
    in_valid = 0;
    rst_n = 0;
    #2;
    n_cmp++;
    if ({out_data, out_valid, frame_done, sync_err, locked} !== '0) begin
      n_err++; $display("FAIL async_reset got data=%h valid=%b lk=%b want zero", out_data, out_valid, locked);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    drive(1, 0, 8'h99, 0);
    n_cmp++;
    if (out_valid !== '0 || locked !== 1'b0 || out_data !== '0) begin
      n_err++; $display("FAIL async_drop got valid=%b lk=%b data=%h want zero", out_valid, locked, out_data);
    end
  endtask

  task automatic test_random();
    logic bad;
    do_reset();
    for (int i = 0; i < 400; i++) begin
`ifdef TDM_DEMUX_PARITY_EN
      bad = ($urandom_range(0, 9) == 0);
`else
      bad = 0;
`endif
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, W'($urandom), bad);
      n_cmp++;
      if (out_data !== e_data) begin
        n_err++; $display("FAIL rand_data[%0d] got %h want %h", i, out_data, e_data);
      end
      n_cmp++;
      if (out_valid !== e_valid) begin
        n_err++; $display("FAIL rand_valid[%0d] got %b want %b", i, out_valid, e_valid);
      end
      n_cmp++;
      if ({frame_done, sync_err, locked} !== {e_fd, e_se, m_lock}) begin
        n_err++; $display("FAIL rand_flags[%0d] got fd/se/lk=%b%b%b want %b%b%b",
                          i, frame_done, sync_err, locked, e_fd, e_se, m_lock);
      end
`ifdef TDM_DEMUX_PARITY_EN
      n_cmp++;
      if (par_err !== e_pe) begin
        n_err++; $display("FAIL rand_par_err[%0d] got %b want %b", i, par_err, e_pe);
      end
`endif
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    do_reset();
    drive(1, 0, 8'h0F, 1);
    n_cmp++;
    if (par_err !== 1'b0 || locked !== 1'b0) begin
      n_err++; $display("FAIL par_hunt got pe=%b lk=%b want 0 0", par_err, locked);
    end
    drive(1, 1, 8'h11, 0);
    drive(1, 0, 8'h03, 1);
    n_cmp++;
    if (par_err !== 1'b1 || out_valid !== '0 || out_data[15:8] !== 8'h00) begin
      n_err++; $display("FAIL par_bad got pe=%b valid=%b ch1=%h want 1 0000 00", par_err, out_valid, out_data[15:8]);
    end
    drive(1, 0, 8'h05, 0);
    n_cmp++;
    if (par_err !== 1'b0 || out_valid !== 4'b0100 || out_data[23:16] !== 8'h05) begin
      n_err++; $display("FAIL par_next got pe=%b valid=%b ch2=%h want 0 0100 05", par_err, out_valid, out_data[23:16]);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_hunt_drop();
    test_resync();
    test_gaps();
    test_async_reset();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
